// File: rtl/key_expansion_pkg.sv
// Shared AES definitions: FSM states, round-constant table, byte-matrix type
// and the cipher-key to byte-matrix mapping used by the round datapath blocks.
package aes_pkg;

  localparam int unsigned NR = 10;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    SUB,
    XOR
  } state_t;

  // Indexed [row][col]; element [r][c] is state/key byte 4*c+r.
  typedef logic [3:0][3:0][7:0] byte_matrix_t;

  // RCON[i] is the constant applied when producing round key i+1.
  localparam logic [9:0][7:0] RCON = {
    8'h36, 8'h1b, 8'h80, 8'h40, 8'h20,
    8'h10, 8'h08, 8'h04, 8'h02, 8'h01
  };

  function automatic logic [7:0] rcon(input logic [3:0] r);
    return (r < 4'd10) ? RCON[r] : '0;
  endfunction

  // Byte 0 of the flat key sits in [127:120].
  function automatic byte_matrix_t bytes_to_matrix(input logic [127:0] k);
    byte_matrix_t m;
    m = '0;
    for (int unsigned i = 0; i < 16; i++) begin
      m[i % 4][i / 4] = k[127 - 8 * i -: 8];
    end
    return m;
  endfunction

endpackage

// File: rtl/key_expansion_if.sv
// Key-schedule handshake bundle: the generator drives the key side (master),
// the round-sequencing controller drives start/cipherkey/ready (slave).
interface key_expansion_if;
  import aes_pkg::*;

  logic         start;
  logic [127:0] cipherkey;
  byte_matrix_t roundkey;
  logic         valid;
  logic         ready;
  logic [3:0]   round;
  logic         last;
  logic         busy;

  modport master (
    input  start, cipherkey, ready,
    output roundkey, valid, round, last, busy
  );

  modport slave (
    output start, cipherkey, ready,
    input  roundkey, valid, round, last, busy
  );

endinterface

// File: rtl/key_expansion_sbox.sv
// Combinational AES forward S-box (byte substitution), shared with subbytes.
module sbox (
  input  logic [7:0] a_i,
  output logic [7:0] y_o
);

  localparam logic [7:0] SBOX [0:255] = '{
    8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
    8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
    8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
    8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
    8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
    8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
    8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
    8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
    8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
    8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
    8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
    8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
    8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
    8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
    8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
    8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
  };

  assign y_o = SBOX[a_i];

endmodule

// File: rtl/key_expansion.sv
// Sequential AES-128 key schedule: one round key per valid/ready transfer,
// each new key built over 4 S-box cycles plus 1 XOR/write cycle.
module key_expansion #(
  parameter int unsigned NR = aes_pkg::NR
) (
  input  logic           clk,
  input  logic           resetn,
  key_expansion_if.master kx
);
  import aes_pkg::*;

  localparam logic [3:0] LAST_ROUND = 4'(NR);

  state_t       state_q, state_d;
  byte_matrix_t key_q, key_d, next_key;
  logic [3:0][7:0] temp_q, temp_d;
  logic [1:0]   cnt_q, cnt_d;
  logic [3:0]   round_q, round_d;
  logic [7:0]   sbox_in, sbox_out;
  logic         valid;

  // RotWord(w3) byte k is row (k+1) mod 4 of column 3; the 2-bit add wraps.
  assign sbox_in = key_q[cnt_q + 2'd1][3];

  sbox u_sbox (
    .a_i (sbox_in),
    .y_o (sbox_out)
  );

  // Word chain w0'..w3' unrolled per row; byte arithmetic carries no bits.
  always_comb begin
    logic [7:0] acc;
    next_key = key_q;
    acc      = '0;
    for (int unsigned r = 0; r < 4; r++) begin
      acc = key_q[r][0] ^ temp_q[r] ^ ((r == 0) ? rcon(round_q) : 8'h00);
      next_key[r][0] = acc;
      for (int unsigned c = 1; c < 4; c++) begin
        acc = key_q[r][c] ^ acc;
        next_key[r][c] = acc;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    key_d   = key_q;
    temp_d  = temp_q;
    cnt_d   = cnt_q;
    round_d = round_q;
    if (kx.start) begin
      state_d = HOLD;
      key_d   = bytes_to_matrix(kx.cipherkey);
      round_d = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: ;
        HOLD: begin
          if (kx.ready) begin
            if (round_q == LAST_ROUND) begin
              state_d = IDLE;
            end else begin
              state_d = SUB;
              cnt_d   = '0;
            end
          end
        end
        SUB: begin
          temp_d[cnt_q] = sbox_out;
          cnt_d         = cnt_q + 2'd1;
          if (cnt_q == 2'd3) state_d = XOR;
        end
        XOR: begin
          key_d   = next_key;
          round_d = round_q + 4'd1;
          state_d = HOLD;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      key_q   <= '0;
      temp_q  <= '0;
      cnt_q   <= '0;
      round_q <= '0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      temp_q  <= temp_d;
      cnt_q   <= cnt_d;
      round_q <= round_d;
    end
  end

  assign valid       = (state_q == HOLD);
  assign kx.valid    = valid;
  assign kx.roundkey = key_q;
  assign kx.round    = round_q;
  assign kx.last     = valid && (round_q == LAST_ROUND);
  assign kx.busy     = (state_q != IDLE);

  a_round_bound: assert property (@(posedge clk) disable iff (!resetn)
    round_q <= LAST_ROUND);

  a_stall_stable: assert property (@(posedge clk) disable iff (!resetn)
    (valid && !kx.ready && !kx.start) |=> (valid && $stable(key_q) && $stable(round_q)));

endmodule
